// File: rtl/qoi_stream_decoder.sv
// qoi_stream_decoder
//   Streaming QOI-style decoder. Compressed bytes arrive on a valid/ready
//   input and decoded {R,G,B} pixels leave on a valid/ready output with full
//   backpressure. One frame of PIXELS pixels is decoded per start pulse.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start                one-cycle pulse, begins a frame (ignored while busy)
//   in_data/valid/ready  compressed byte stream
//   pix_data/valid/ready decoded pixel stream, pix_data = {R,G,B}
//   busy                 frame in progress
//   done                 one-cycle pulse after the last pixel is accepted
//   err                  sticky: reserved opcode or run overflow
//   pix_count            pixels accepted in the current frame
module qoi_stream_decoder #(
  parameter int BPC         = 4,
  parameter int INDEX_DEPTH = 64,
  parameter int PIXELS      = 76800,
  parameter int CW          = $clog2(PIXELS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [3*BPC-1:0] pix_data,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CW-1:0]    pix_count
);
  localparam int PW = 3 * BPC;
  localparam int NB = (PW + 7) / 8;
  localparam int IW = $clog2(INDEX_DEPTH);
  localparam int AW = BPC + 10;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_OP    = 3'd1;
  localparam logic [2:0] S_ARG   = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_FLUSH = 3'd4;

  logic [2:0]      r_state;
  logic [PW-1:0]   r_prev;
  logic [PW-1:0]   r_index [INDEX_DEPTH];
  logic [5:0]      r_run;
  logic [8*NB-1:0] r_arg;
  logic [2:0]      r_argcnt;
  logic            r_luma;
  logic [5:0]      r_lg;
  logic [CW-1:0]   r_emit;
  logic [PW-1:0]   r_pix_data;
  logic            r_pix_valid;
  logic            r_busy;
  logic            r_done;
  logic            r_err;
  logic [CW-1:0]   r_pix_count;

  logic              w_hs_out, w_in_hs, w_load, w_err_set, w_done;
  logic [2:0]        w_nstate;
  logic [5:0]        w_run_nxt;
  logic [PW-1:0]     w_new;
  logic [8*NB+7:0]   w_cat;
  logic signed [9:0] w_dr, w_dg, w_db, w_lg, w_lr, w_lb;
  logic              w_unused;

  function automatic logic [BPC-1:0] f_add(input logic [BPC-1:0] p, input logic signed [9:0] d);
    logic [AW-1:0] dx;
    dx = {{(AW-10){d[9]}}, d};
    return BPC'(dx + AW'(p));
  endfunction

  function automatic logic [IW-1:0] f_hash(input logic [PW-1:0] px);
    return IW'(32'(px[PW-1 -: BPC]) * 3 + 32'(px[2*BPC-1 -: BPC]) * 5 + 32'(px[BPC-1:0]) * 7);
  endfunction

  assign w_hs_out = r_pix_valid && pix_ready;
  assign in_ready = r_busy && ((r_state == S_OP) || (r_state == S_ARG)) &&
                    (!r_pix_valid || pix_ready);
  assign w_in_hs  = in_valid && in_ready;

  // Final RGB byte joined with the earlier ones; colour sits MSB-first.
  assign w_cat    = {r_arg, in_data};
  assign w_unused = ^{w_cat[8*NB+7:8*NB], w_cat[7:0]};

  assign w_dr = $signed({8'd0, in_data[5:4]}) - 10'sd2;
  assign w_dg = $signed({8'd0, in_data[3:2]}) - 10'sd2;
  assign w_db = $signed({8'd0, in_data[1:0]}) - 10'sd2;
  assign w_lg = $signed({4'd0, r_lg}) - 10'sd32;
  assign w_lr = w_lg + $signed({6'd0, in_data[7:4]}) - 10'sd8;
  assign w_lb = w_lg + $signed({6'd0, in_data[3:0]}) - 10'sd8;

  always_comb begin
    w_load    = 1'b0;
    w_new     = r_prev;
    w_nstate  = r_state;
    w_run_nxt = r_run;
    w_err_set = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      S_OP: if (w_in_hs) begin
        if (in_data == 8'hFE) w_nstate = S_ARG;
        else if (in_data == 8'hFF) w_err_set = 1'b1;
        else begin
          case (in_data[7:6])
            2'b00: begin
              w_load = 1'b1;
              w_new  = r_index[in_data[IW-1:0]];
            end
            2'b01: begin
              w_load = 1'b1;
              w_new  = {f_add(r_prev[PW-1 -: BPC], w_dr),
                        f_add(r_prev[2*BPC-1 -: BPC], w_dg),
                        f_add(r_prev[BPC-1:0], w_db)};
            end
            2'b10: w_nstate = S_ARG;
            default: begin
              w_load    = 1'b1;
              w_run_nxt = in_data[5:0];
              w_nstate  = (in_data[5:0] != 6'd0) ? S_RUN : S_OP;
            end
          endcase
        end
      end
      S_ARG: if (w_in_hs) begin
        if (r_luma) begin
          w_load   = 1'b1;
          w_new    = {f_add(r_prev[PW-1 -: BPC], w_lr),
                      f_add(r_prev[2*BPC-1 -: BPC], w_lg),
                      f_add(r_prev[BPC-1:0], w_lb)};
          w_nstate = S_OP;
        end else if (r_argcnt == 3'(NB - 1)) begin
          w_load   = 1'b1;
          w_new    = w_cat[8*NB-1 -: PW];
          w_nstate = S_OP;
        end
      end
      S_RUN: if (w_hs_out) begin
        w_load    = 1'b1;
        w_run_nxt = r_run - 6'd1;
        w_nstate  = (r_run == 6'd1) ? S_OP : S_RUN;
      end
      S_FLUSH: if (w_hs_out) begin
        w_done   = 1'b1;
        w_nstate = S_IDLE;
      end
      default: ;
    endcase
    // Loading the frame's last pixel stops input; leftover repeats are an overflow.
    if (w_load && (r_emit == CW'(PIXELS - 1))) begin
      w_nstate = S_FLUSH;
      if (w_run_nxt != 6'd0) w_err_set = 1'b1;
      w_run_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_prev      <= '0;
      for (int unsigned i = 0; i < INDEX_DEPTH; i++) r_index[i] <= '0;
      r_run       <= '0;
      r_arg       <= '0;
      r_argcnt    <= '0;
      r_luma      <= 1'b0;
      r_lg        <= '0;
      r_emit      <= '0;
      r_pix_data  <= '0;
      r_pix_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_pix_count <= '0;
    end else if (start && (r_state == S_IDLE)) begin
      r_state     <= S_OP;
      r_prev      <= '0;
      for (int unsigned i = 0; i < INDEX_DEPTH; i++) r_index[i] <= '0;
      r_run       <= '0;
      r_emit      <= '0;
      r_pix_valid <= 1'b0;
      r_busy      <= 1'b1;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_pix_count <= '0;
    end else begin
      r_state <= w_nstate;
      r_run   <= w_run_nxt;
      r_done  <= w_done;
      if (w_err_set) r_err <= 1'b1;
      if (w_done) r_busy <= 1'b0;
      if (w_hs_out) begin
        r_pix_valid <= 1'b0;
        r_pix_count <= r_pix_count + CW'(1);
      end
      if (w_load) begin
        r_pix_valid             <= 1'b1;
        r_pix_data              <= w_new;
        r_prev                  <= w_new;
        r_index[f_hash(w_new)]  <= w_new;
        r_emit                  <= r_emit + CW'(1);
      end
      if ((r_state == S_OP) && w_in_hs) begin
        if (in_data == 8'hFE) begin
          r_luma   <= 1'b0;
          r_argcnt <= '0;
        end else if (in_data[7:6] == 2'b10) begin
          r_luma <= 1'b1;
          r_lg   <= in_data[5:0];
        end
      end
      if ((r_state == S_ARG) && w_in_hs && !r_luma) begin
        r_arg    <= w_cat[8*NB-1:0];
        r_argcnt <= r_argcnt + 3'd1;
      end
    end
  end

  assign pix_data  = r_pix_data;
  assign pix_valid = r_pix_valid;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign pix_count = r_pix_count;
endmodule

// File: tb/tb_qoi_stream_decoder.sv
// tb_qoi_stream_decoder
//   Directed-vector bench: instance A (PIXELS=64) covers decoding, index,
//   wrap, backpressure, reserved opcode and mid-frame reset; instance B
//   (PIXELS=4) covers frame end and run truncation.
module tb_qoi_stream_decoder;
  localparam int PA  = 64;
  localparam int PB  = 4;
  localparam int CWA = $clog2(PA + 1);
  localparam int CWB = $clog2(PB + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic st_a, iv_a, ir_a, pv_a, pr_a, busy_a, done_a, err_a;
  logic st_b, iv_b, ir_b, pv_b, pr_b, busy_b, done_b, err_b;
  logic [7:0]     id_a, id_b;
  logic [11:0]    pd_a, pd_b;
  logic [CWA-1:0] cnt_a;
  logic [CWB-1:0] cnt_b;

  qoi_stream_decoder #(.BPC(4), .INDEX_DEPTH(64), .PIXELS(PA)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(st_a),
    .in_data(id_a), .in_valid(iv_a), .in_ready(ir_a),
    .pix_data(pd_a), .pix_valid(pv_a), .pix_ready(pr_a),
    .busy(busy_a), .done(done_a), .err(err_a), .pix_count(cnt_a)
  );

  qoi_stream_decoder #(.BPC(4), .INDEX_DEPTH(64), .PIXELS(PB)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(st_b),
    .in_data(id_b), .in_valid(iv_b), .in_ready(ir_b),
    .pix_data(pd_b), .pix_valid(pv_b), .pix_ready(pr_b),
    .busy(busy_b), .done(done_b), .err(err_b), .pix_count(cnt_b)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [11:0] qa[$];
  logic [11:0] qb[$];
  int unsigned done_b_cnt = 0;
  int unsigned q_at_done  = 0;

  always @(posedge clk) begin
    if (pv_a && pr_a) qa.push_back(pd_a);
    if (pv_b && pr_b) qb.push_back(pd_b);
    if (done_b) begin
      done_b_cnt++;
      q_at_done = qb.size();
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input bit w, input logic [7:0] b);
    int unsigned t;
    bit ok;
    t  = 0;
    ok = 1'b0;
    @(negedge clk);
    if (w) begin id_b = b; iv_b = 1'b1; end
    else   begin id_a = b; iv_a = 1'b1; end
    while (!ok && t < 200) begin
      #4;
      ok = w ? ir_b : ir_a;
      @(posedge clk);
      if (!ok) @(negedge clk);
      t++;
    end
    #1;
    iv_a = 1'b0;
    iv_b = 1'b0;
    if (!ok) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_start(input bit w);
    @(negedge clk);
    if (w) st_b = 1'b1; else st_a = 1'b1;
    @(negedge clk);
    st_a = 1'b0;
    st_b = 1'b0;
  endtask

  task automatic wait_q(input bit w, input int unsigned n, input string tag);
    int unsigned t;
    t = 0;
    while (((w ? qb.size() : qa.size()) < n) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check(tag, w ? qb.size() : qa.size(), n);
  endtask

  task automatic expect_pix(input bit w, input logic [11:0] exp, input string tag);
    logic [11:0] v;
    if ((w ? qb.size() : qa.size()) == 0) check(tag, 32'hFFFF_FFFF, {20'd0, exp});
    else begin
      v = w ? qb.pop_front() : qa.pop_front();
      check(tag, {20'd0, v}, {20'd0, exp});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    st_a = 1'b0; iv_a = 1'b0; id_a = '0; pr_a = 1'b1;
    st_b = 1'b0; iv_b = 1'b0; id_b = '0; pr_b = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready",  ir_a,   0);
    check("rst_pix_valid", pv_a,   0);
    check("rst_pix_data",  pd_a,   0);
    check("rst_busy",      busy_a, 0);
    check("rst_done",      done_a, 0);
    check("rst_err",       err_a,  0);
    check("rst_count",     cnt_a,  0);
    rst_n = 1'b1;

    // Scenario 1: RGB, DIFF, RUN
    pulse_start(0);
    check("s1_busy", busy_a, 1);
    send(0, 8'hFE); send(0, 8'h12); send(0, 8'h30); send(0, 8'h6B); send(0, 8'hC2);
    wait_q(0, 5, "s1_npix");
    expect_pix(0, 12'h123, "s1_p0");
    for (int i = 1; i < 5; i++) expect_pix(0, 12'h124, "s1_run");
    check("s1_count", cnt_a, 5);
    check("s1_err",   err_a, 0);

    // Scenario 2: INDEX of hash 34, then LUMA
    send(0, 8'h22);
    wait_q(0, 1, "s2_nidx");
    expect_pix(0, 12'h123, "s2_index");
    send(0, 8'hA1); send(0, 8'h79);
    wait_q(0, 1, "s2_nluma");
    expect_pix(0, 12'h135, "s2_luma");
    check("s2_count", cnt_a, 7);

    // Scenario 5: short frame, run truncation, done, restart
    pulse_start(1);
    check("s5_busy", busy_b, 1);
    send(1, 8'hFE); send(1, 8'h12); send(1, 8'h30); send(1, 8'hC5);
    wait_q(1, 4, "s5_npix");
    repeat (4) @(negedge clk);
    check("s5_npix_final", qb.size(), 4);
    for (int i = 0; i < 4; i++) expect_pix(1, 12'h123, "s5_pix");
    check("s5_done_cnt", done_b_cnt, 1);
    check("s5_done_at",  q_at_done,  4);
    check("s5_err",      err_b,  1);
    check("s5_busy_end", busy_b, 0);
    check("s5_count",    cnt_b,  4);
    id_b = 8'h00; iv_b = 1'b1;
    #1;
    check("s5_in_ready", ir_b, 0);
    iv_b = 1'b0;
    pulse_start(1);
    check("s5_re_err",   err_b,  0);
    check("s5_re_count", cnt_b,  0);
    check("s5_re_busy",  busy_b, 1);

    // Scenario 3: fresh frame, index 0 and DIFF wrap
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    qa.delete();
    pulse_start(0);
    send(0, 8'h00);
    wait_q(0, 1, "s3_nidx");
    expect_pix(0, 12'h000, "s3_index0");
    send(0, 8'h40);
    wait_q(0, 1, "s3_ndiff");
    expect_pix(0, 12'hEEE, "s3_wrap");

    // Scenario 4: backpressure during a 6-pixel run
    pr_a = 1'b0;
    send(0, 8'hC5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("s4_hold_valid", pv_a, 1);
      check("s4_hold_data",  pd_a, 12'hEEE);
      check("s4_hold_ready", ir_a, 0);
    end
    pr_a = 1'b1;
    wait_q(0, 6, "s4_npix");
    repeat (4) @(negedge clk);
    check("s4_npix_final", qa.size(), 6);
    for (int i = 0; i < 6; i++) expect_pix(0, 12'hEEE, "s4_pix");
    check("s4_in_ready", ir_a, 1);
    check("s4_count", cnt_a, 8);

    // Scenario 6: reserved opcode, then reset mid-run
    send(0, 8'hFF);
    repeat (3) @(negedge clk);
    check("s6_err", err_a, 1);
    check("s6_nopix", qa.size(), 0);
    send(0, 8'h6B);
    wait_q(0, 1, "s6_ndiff");
    expect_pix(0, 12'hEEF, "s6_diff");
    send(0, 8'hC9);
    wait_q(0, 3, "s6_nrun");
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    check("s6_rst_in_ready",  ir_a,   0);
    check("s6_rst_pix_valid", pv_a,   0);
    check("s6_rst_pix_data",  pd_a,   0);
    check("s6_rst_busy",      busy_a, 0);
    check("s6_rst_err",       err_a,  0);
    check("s6_rst_count",     cnt_a,  0);
    check("s6_rst_done",      done_a, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/qoi_stream_decoder.md
Name: qoi_stream_decoder

Overview:
- Streaming, parametrised successor to the frame-buffer QOI RGB444 decoder.
- Consumes the compressed byte stream through a valid/ready input and emits decoded pixels through a valid/ready output with full backpressure.
- Channel width, colour-index depth and frame length are generalised.
- Sits between the stream store/SPI reader and the display/VGA line buffer; decodes exactly one frame per `start`.

Parameters:
- BPC, 4, bits per colour channel; pixel = {R,G,B}, 3*BPC bits.
- INDEX_DEPTH, 64, colour-index entries; power of 2, ≤64.
- PIXELS, 76800, pixels per frame.
- CW, $clog2(PIXELS+1), width of pix_count.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: clear state, begin new frame (ignored while busy)
- in_data  in  8  compressed stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  decoder accepts byte this cycle
- pix_data  out  3*BPC  decoded pixel {R,G,B}
- pix_valid  out  1  pix_data valid
- pix_ready  in  1  sink accepts pixel
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse when last pixel of frame accepted
- err  out  1  sticky until next start: reserved opcode or run overflow
- pix_count  out  CW  pixels accepted in current frame

Behaviour:
- Clocking and reset:
  - Single clock domain; all state flops reset asynchronously on rst_n=0.
  - Reset values: in_ready=0, pix_valid=0, pix_data=0, busy=0, done=0, err=0, pix_count=0.
  - Reset also clears prev pixel to 0, all index entries to 0, run counter to 0, and FSM to IDLE.
- start in IDLE:
  - Clears prev pixel, index, err and pix_count; FSM → OP; busy=1.
- FSM states: IDLE, OP, ARG, RUN, FLUSH.
  - OP: awaiting opcode byte.
  - ARG: collecting extra bytes (RGB: 2 bytes for BPC=4, generally ceil(3*BPC/8); LUMA: 1 byte).
  - RUN: emitting repeats.
  - FLUSH: last pixel waiting for acceptance.
- Opcodes, decoded from the first byte:
  - 8'hFE RGB: absolute colour packed MSB-first in following bytes; padding bits ignored.
  - 8'hFF: reserved. Byte is consumed, err=1, no pixel emitted.
  - 00iiiiii INDEX: pixel = index[i mod INDEX_DEPTH].
  - 01rrggbb DIFF: each field minus 2, added to prev channel.
  - 10gggggg LUMA: dg = g-32. Next byte {a,b}: dr = dg+a-8, db = dg+b-8.
  - 11nnnnnn RUN (not FE/FF): repeat prev pixel n+1 times (1..62).
- Arithmetic: all channel sums are modulo 2^BPC (wrap, no saturation).
- Hash: (3R+5G+7B) mod INDEX_DEPTH, computed at full precision.
- Output register:
  - Decoded pixel is registered into pix_data/prev at the same edge the index entry index[hash(pixel)] is written.
  - A following INDEX op therefore reads the updated entry; no bypass is needed.
- in_ready: high only in OP/ARG when busy and (!pix_valid || pix_ready).
  - Byte transfer on in_valid&&in_ready.
- Latency: pixel valid the cycle after the final byte of its op transfers.
  - Single-byte ops sustain 1 pixel/cycle with pix_ready=1.
- RUN state: in_ready=0; pixels are emitted on consecutive handshakes.
- Output handshake: pix_data and pix_valid are held stable while pix_valid && !pix_ready.
- Frame end:
  - On the handshake making pix_count==PIXELS: done pulses, busy=0, FSM → IDLE.
  - Further input bytes are not accepted.
- Run overflow: a run exceeding remaining pixels is truncated at PIXELS and sets err.
- start while busy is ignored.
- rst_n low mid-frame aborts immediately to reset values; no pixel is emitted.

Test Plan:
1. start; bytes FE,12,30,6B,C2 with pix_ready=1 → pixels 0x123, 0x124, 0x124, 0x124, 0x124; pix_count=5; err=0.
2. After scenario 1 bytes, send 22 (hash(0x123)=34) → 0x123. Then A1,79 (LUMA dg=+1, dr=0, db=+2) → 0x135.
3. Wrap: start, byte 00 (index[0]=0) → 0x000. Then byte 40 (DIFF −2,−2,−2) → 0xEEE.
4. Backpressure: during run C5, hold pix_ready=0 for 5 cycles → pix_data stable, pix_valid=1, in_ready=0. Exactly 6 pixels delivered once released, none lost or duplicated.
5. PIXELS=4: start, FE,12,30, C5 → 4 pixels (0x123 ×4), done pulse on 4th handshake, err=1, in_ready=0 afterwards. A second start restarts with err=0, pix_count=0.
6. Reserved byte FF mid-stream → err=1, no pixel, next op decodes normally. Assert rst_n=0 mid-run → all outputs at reset values next cycle.
